// File: rtl/hazard_ctrl_unit_5s.sv
// hazard_ctrl_unit_5s: forwarding, ID bypass, load-use stall and branch flush control for a 5-stage pipeline
// Ports:
//   clk, rst_n                          clock (rising edge), asynchronous active-low reset
//   i_id_rs1/i_id_rs2                   source registers of the instruction in ID
//   i_ex_rs1/i_ex_rs2/i_ex_rd           sources and destination of the instruction in EX
//   i_ex_rb_wr/i_ex_dm_rd               EX writes regfile / EX is a load
//   i_mem_rd/i_mem_rb_wr                MEM destination and write enable
//   i_wb_rd/i_wb_rb_wr                  WB destination and write enable
//   i_pc_sel                            branch/jump taken, resolved in EX
//   o_fwd_a/o_fwd_b                     EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   o_byp_a_d/o_byp_b_d                 ID operand takes WB write data
//   o_stall/o_flush_if_id/o_flush_id_ex pipeline-register controls
//   o_stall_cnt/o_flush_cnt             perf counters, live only with HAZARD_PERF_CNT_EN defined
module hazard_ctrl_unit_5s #(
  parameter int REG_AW        = 5,
  parameter int LOAD_STALL_CY = 1,
  parameter int FLUSH_CY      = 1,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_ex_rs1,
  input  logic [REG_AW-1:0] i_ex_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_rb_wr,
  input  logic              i_ex_dm_rd,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_rb_wr,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_rb_wr,
  input  logic              i_pc_sel,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_byp_a_d,
  output logic              o_byp_b_d,
  output logic              o_stall,
  output logic              o_flush_if_id,
  output logic              o_flush_id_ex,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);
  localparam int MAX_CY = (LOAD_STALL_CY > FLUSH_CY) ? LOAD_STALL_CY : FLUSH_CY;
  localparam int CW = $clog2(MAX_CY + 1);
  localparam logic [CW-1:0] LS_INIT = CW'(LOAD_STALL_CY - 1);
  localparam logic [CW-1:0] FL_INIT = CW'(FLUSH_CY - 1);
  typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic w_mem_a, w_mem_b, w_wb_a, w_wb_b, w_byp_a, w_byp_b, w_lu_haz;
  logic w_stall, w_flush_if_id, w_flush_id_ex;
  logic [1:0] w_fwd_a, w_fwd_b;
  assign w_mem_a  = i_mem_rb_wr & (i_mem_rd != '0) & (i_mem_rd == i_ex_rs1);
  assign w_mem_b  = i_mem_rb_wr & (i_mem_rd != '0) & (i_mem_rd == i_ex_rs2);
  assign w_wb_a   = i_wb_rb_wr & (i_wb_rd != '0) & (i_wb_rd == i_ex_rs1);
  assign w_wb_b   = i_wb_rb_wr & (i_wb_rd != '0) & (i_wb_rd == i_ex_rs2);
  assign w_byp_a  = i_wb_rb_wr & (i_wb_rd != '0) & (i_wb_rd == i_id_rs1);
  assign w_byp_b  = i_wb_rb_wr & (i_wb_rd != '0) & (i_wb_rd == i_id_rs2);
  assign w_lu_haz = i_ex_dm_rd & i_ex_rb_wr & (i_ex_rd != '0) & ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));
  // the younger result (EX/MEM) wins over MEM/WB
  assign w_fwd_a  = w_mem_a ? 2'b01 : w_wb_a ? 2'b10 : 2'b00;
  assign w_fwd_b  = w_mem_b ? 2'b01 : w_wb_b ? 2'b10 : 2'b00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // a taken branch overrides everything, including an open stall or flush window
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stall       = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    if (i_pc_sel) begin
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
      w_state_nxt   = (FLUSH_CY > 1) ? FLUSH : RUN;
      w_cnt_nxt     = (FLUSH_CY > 1) ? FL_INIT : r_cnt;
    end else if (r_state == FLUSH) begin
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
      w_cnt_nxt     = r_cnt - CW'(1);
      w_state_nxt   = (r_cnt == CW'(1)) ? RUN : FLUSH;
    end else if (r_state == LSTALL) begin
      w_stall       = 1'b1;
      w_flush_id_ex = 1'b1;
      w_cnt_nxt     = r_cnt - CW'(1);
      w_state_nxt   = (r_cnt == CW'(1)) ? RUN : LSTALL;
    end else if (w_lu_haz) begin
      w_stall       = 1'b1;
      w_flush_id_ex = 1'b1;
      w_state_nxt   = (LOAD_STALL_CY > 1) ? LSTALL : RUN;
      w_cnt_nxt     = (LOAD_STALL_CY > 1) ? LS_INIT : r_cnt;
    end
  end
  // outputs forced low while reset is held, independent of the clock
  assign o_fwd_a       = {2{rst_n}} & w_fwd_a;
  assign o_fwd_b       = {2{rst_n}} & w_fwd_b;
  assign o_byp_a_d     = rst_n & w_byp_a;
  assign o_byp_b_d     = rst_n & w_byp_b;
  assign o_stall       = rst_n & w_stall;
  assign o_flush_if_id = rst_n & w_flush_if_id;
  assign o_flush_id_ex = rst_n & w_flush_id_ex;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall);
      r_flush_cnt <= r_flush_cnt + CNT_W'(i_pc_sel);
    end
  end
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif
endmodule
